// File: rtl/serial_digit_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_digit_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A one-digit configuration still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/serial_digit_adder_slice.sv
// DIGIT-bit ripple-carry slice; also exposes the carry into its top bit for overflow.
module full_adder_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_out_o,
  output logic             c_msb_in_o
);

  logic [DIGIT:0] c;

  // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_out_o    = c[DIGIT];
  assign c_msb_in_o = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle WIDTH-bit adder, DIGIT bits per cycle, LSB digit first, valid/ready on both sides.
// Optional subtract mode (extra `sub` input) when SERIAL_DIGIT_ADDER_SUB_EN is defined.
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [DIGIT-1:0] slice_s;
  logic             slice_cout, slice_cmsb;

  full_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i        (a_q[DIGIT-1:0]),
    .b_i        (b_q[DIGIT-1:0]),
    .c_i        (carry_q),
    .s_o        (slice_s),
    .c_out_o    (slice_cout),
    .c_msb_in_o (slice_cmsb)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = a;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
          // Subtraction is a + ~b + 1, so cin is meaningless in that mode.
          b_d        = sub ? ~b : b;
          carry_d    = sub ? 1'b1 : cin;
`else
          b_d        = b;
          carry_d    = cin;
`endif
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cout_d      = slice_cout;
          ovf_d       = slice_cmsb ^ slice_cout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the operand shift registers are reset too, so a reset mid-op leaves no stale digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboard bench for serial_digit_adder: WIDTH=8/DIGIT=2 main DUT plus DIGIT=1 and DIGIT=8 instances.
module tb_serial_digit_adder;

  localparam int W    = 8;
  localparam int D    = 2;
  localparam int NDIG = W / D;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout, ovf;

  logic         sw_valid [2] = '{1'b0, 1'b0};
  logic         sw_ready [2];
  logic         sw_ovalid[2];
  logic [W-1:0] sw_sum   [2];
  logic         sw_cout  [2];
  logic         sw_ovf   [2];
  logic [W-1:0] sw_a = '0, sw_b = '0;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  bit   force_low  = 1'b0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  for (genvar k = 0; k < 2; k++) begin : g_sw
    serial_digit_adder #(.WIDTH(W), .DIGIT(k == 0 ? 1 : 8)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid[k]),
      .in_ready  (sw_ready[k]),
      .a         (sw_a),
      .b         (sw_b),
      .cin       (1'b0),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
      .sub       (1'b0),
`endif
      .out_valid (sw_ovalid[k]),
      .out_ready (1'b1),
      .sum       (sw_sum[k]),
      .cout      (sw_cout[k]),
      .ovf       (sw_ovf[k])
    );
  end

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input bit s);
    exp_t e;
    int   u, sv;
    if (s) begin
      u   = int'(x) - int'(y);
      sv  = int'($signed(x)) - int'($signed(y));
      e.c = (x >= y);
    end else begin
      u   = int'(x) + int'(y) + int'(c);
      sv  = int'($signed(x)) + int'($signed(y)) + int'(c);
      e.c = (u > 255);
    end
    e.s = W'(u);
    e.v = (sv > 127) || (sv < -128);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  always @(posedge clk) begin
    #1;
    if (force_low)       out_ready = 1'b0;
    else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    else                 out_ready = 1'b1;
  end

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        timeout("unexpected_result");
      end else begin
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("cout", 32'(cout), 32'(e.c));
        check("ovf", 32'(ovf), 32'(e.v));
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        return;
      end
      in_valid = 1'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
    end
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit s);
    bit ok;
    wait_ready(ok);
    if (!ok) begin
      timeout("in_ready_wait");
      return;
    end
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    sub      = s;
`endif
    @(posedge clk);
    q.push_back(model(x, y, c, s));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_latency(input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0 && !out_valid) return;
    end
    timeout("drain");
  endtask

  task automatic sweep(input int k, input int exp_lat);
    exp_t e;
    int   lat = 0;
    e = model(8'h80, 8'h80, 1'b0, 1'b0);
    @(negedge clk);
    check("sw_in_ready", 32'(sw_ready[k]), 32'd1);
    sw_a        = 8'h80;
    sw_b        = 8'h80;
    sw_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    sw_valid[k] = 1'b0;
    while (!sw_ovalid[k] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("sw_latency", 32'(lat), 32'(exp_lat));
    check("sw_sum", 32'(sw_sum[k]), 32'(e.s));
    check("sw_cout", 32'(sw_cout[k]), 32'(e.c));
    check("sw_ovf", 32'(sw_ovf[k]), 32'(e.v));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    check_latency(NDIG);
    drain();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'hFF, 8'h00, 1'b1, 1'b0);
    drain();

    // Backpressure: result must hold and stray in_valid pulses must be ignored.
    force_low = 1'b1;
    @(posedge clk);
    #2;
    do_op(8'h37, 8'h44, 1'b1, 1'b0);
    e    = model(8'h37, 8'h44, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #2;
      seen = out_valid;
    end
    if (!seen) timeout("bp_out_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_sum", 32'(sum), 32'(e.s));
      check("bp_cout", 32'(cout), 32'(e.c));
      check("bp_ovf", 32'(ovf), 32'(e.v));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    force_low = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_single_capture", 32'(q.size()), 32'd0);

    // Reset while BUSY with cnt==2.
    do_op(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    void'(q.pop_back());
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready_release", 32'(in_ready), 32'd1);
    do_op(8'h01, 8'h01, 1'b0, 1'b0);
    drain();

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    do_op(8'h10, 8'h20, 1'b0, 1'b1);
    do_op(8'h80, 8'h01, 1'b1, 1'b1);
    drain();
`endif

    rand_ready = 1'b1;
    repeat (40) begin
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
      do_op(pick(), pick(), 1'($urandom), 1'($urandom));
`else
      do_op(pick(), pick(), 1'($urandom), 1'b0);
`endif
    end
    drain();
    rand_ready = 1'b0;
    in_valid   = 1'b0;

    sweep(0, 8);
    sweep(1, 1);

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
